// File: rtl/d_flipflop.sv
// Positive-edge D-type register with asynchronous active-low clear and
// complementary outputs; q_bar is always the bitwise inverse of q.
module d_flipflop #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = d;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its pre-edge inputs, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  // Both outputs come from the one register, so they can never disagree.
  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: tb/tb_d_flipflop.sv
// Directed bench for d_flipflop: reset, capture, hold, async clear, release,
// and a randomised run checking q against a sampled-d model and q_bar == ~q.
`timescale 1ns / 100ps
module tb_d_flipflop;

  logic clk = 1'b0;
  logic rst;
  logic [0:0] d;
  logic [0:0] q;
  logic [0:0] q_bar;

  int total = 0;
  int bad   = 0;

  d_flipflop dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .q     (q),
    .q_bar (q_bar)
  );

  // Rising edges at t = 2, 6, 10, ...
  always #2 clk = ~clk;

  task automatic check(input string tag, input logic [0:0] observed,
                       input logic [0:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, observed,
             expected, $realtime);
    end
  endtask

  initial begin
    logic [0:0] exp_q;
    int         h;
    int         n_changes;

    // Power-up reset, edge at t=2 must be ignored.
    rst = 1'b0;
    d   = 1'b0;
    #1;    // t=1
    check("por_q", q, 1'b0);
    check("por_qbar", q_bar, 1'b1);
    #2;    // t=3
    check("por_edge_q", q, 1'b0);
    check("por_edge_qbar", q_bar, 1'b1);

    // Release and capture on the edge at t=6.
    rst = 1'b1;
    d   = 1'b1;
    #2;    // t=5
    check("pre_capture_q", q, 1'b0);
    #2;    // t=7
    check("capture_q", q, 1'b1);
    check("capture_qbar", q_bar, 1'b0);

    // Hold between edges while d toggles.
    d = 1'b0;
    #1;    // t=8
    check("hold_q_t8", q, 1'b1);
    d = 1'b1;
    #1;    // t=9
    check("hold_q_t9", q, 1'b1);
    #2;    // t=11 (edge at 10 saw d=1)
    check("edge10_q", q, 1'b1);

    // Capture a zero, then a one.
    d = 1'b0;
    #4;    // t=15 (edge at 14)
    check("capture0_q", q, 1'b0);
    check("capture0_qbar", q_bar, 1'b1);
    d = 1'b1;
    #4;    // t=19 (edge at 18)
    check("capture1_q", q, 1'b1);

    // Asynchronous clear between edges.
    #2;    // t=21
    rst = 1'b0;
    #0.5;  // t=21.5, no clock edge since 18
    check("async_clr_q", q, 1'b0);
    check("async_clr_qbar", q_bar, 1'b1);
    #1.5;  // t=23, edge at 22 with d=1 ignored
    check("held_rst_q", q, 1'b0);
    check("held_rst_qbar", q_bar, 1'b1);

    // Release; first capture at t=26.
    #1;    // t=24
    rst = 1'b1;
    d   = 1'b1;
    #1;    // t=25
    check("release_pre_q", q, 1'b0);
    #2;    // t=27
    check("release_cap_q", q, 1'b1);

    // Randomised run: d changes at half-unit times every 3 units, so it never
    // coincides with an edge; check at every half unit except edge instants.
    exp_q     = 1'b1;
    n_changes = 0;
    for (int i = 1; i <= 80; i++) begin
      #0.5;
      h = 54 + i;                      // current time in half units
      if (h % 8 == 4) begin
        exp_q = d;                     // edge now; d is stable here
      end else begin
        if ((h % 6 == 1) && (n_changes < 12)) begin
          d = 1'($urandom_range(0, 1));
          n_changes++;
        end
        check("rand_q", q, exp_q);
        check("rand_qbar", q_bar, ~q);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
